// File: rtl/median_stream_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | median_pkg : FSM state type and counter-width helper. Rev 1.0      |
// +--------------------------------------------------------------------+
package median_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SORT = 2'd1,
    OUT  = 2'd2
  } state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/median_stream_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | median_stream_if : sample-in / result-out handshake bundle. Rev 1.0|
// +--------------------------------------------------------------------+
interface median_stream_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface
`default_nettype wire

// File: rtl/median_stream_cmp_swap.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cmp_swap : combinational unsigned compare-exchange. Rev 1.0        |
// +--------------------------------------------------------------------+
module cmp_swap #(
  parameter int WIDTH = 8
) (
  input  wire logic [WIDTH-1:0] A,
  input  wire logic [WIDTH-1:0] B,
  output logic      [WIDTH-1:0] MAX,
  output logic      [WIDTH-1:0] MIN
);

  logic a_gt_b;

  assign a_gt_b = (A > B);
  assign MAX    = a_gt_b ? A : B;
  assign MIN    = a_gt_b ? B : A;

endmodule
`default_nettype wire

// File: rtl/median_stream.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | median_stream : windowed order-statistic filter over N samples;    |
// | MEDIAN_STREAM_RANK_EN adds a runtime rank port. Rev 1.0            |
// +--------------------------------------------------------------------+
module median_stream
  import median_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 9
) (
  input  wire logic                   CLK,
  input  wire logic                   nRST,
`ifdef MEDIAN_STREAM_RANK_EN
  input  wire logic [$clog2(N+1)-1:0] rank,
`endif
  median_stream_if.slave              bus
);

  localparam int            CW      = cnt_w(N);
  localparam logic [CW-1:0] C_LAST  = CW'(N - 1);
  localparam logic [CW-1:0] C_FINAL = CW'(N - 2);
  localparam logic [CW-1:0] C_PMED  = CW'((N - 1) / 2);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q [N];
  logic [WIDTH-1:0] r_d [N];
  logic [CW-1:0]    cnt_q,  cnt_d;
  logic [CW-1:0]    pass_q, pass_d;
  logic [CW-1:0]    cyc_q,  cyc_d;
  logic [CW-1:0]    ptgt_q, ptgt_d;
  logic [CW-1:0]    rank_ptgt;
  logic [WIDTH-1:0] cs_max, cs_min;
  logic             accept;

  // Number of full max-removal passes before the final selection sweep.
`ifdef MEDIAN_STREAM_RANK_EN
  localparam int RW = $clog2(N + 1);
  always_comb begin
    if (rank == '0 || rank > RW'(N)) rank_ptgt = C_PMED;
    else                             rank_ptgt = CW'(rank - RW'(1));
  end
`else
  assign rank_ptgt = C_PMED;
`endif

  cmp_swap #(.WIDTH(WIDTH)) u_cmp_swap (
    .A   (r_q[N-2]),
    .B   (r_q[N-1]),
    .MAX (cs_max),
    .MIN (cs_min)
  );

  assign accept = bus.in_valid && (state_q == LOAD);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      pass_q  <= '0;
      cyc_q   <= '0;
      ptgt_q  <= '0;
      for (int i = 0; i < N; i++) r_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      cyc_q   <= cyc_d;
      ptgt_q  <= ptgt_d;
      r_q     <= r_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (accept && cnt_q == C_LAST)              state_d = SORT;
      SORT:    if (pass_q == ptgt_q && cyc_q == C_FINAL)   state_d = OUT;
      OUT:     if (bus.out_ready)                          state_d = LOAD;
      default:                                             state_d = LOAD;
    endcase
  end

  always_comb begin
    r_d    = r_q;
    cnt_d  = cnt_q;
    pass_d = pass_q;
    cyc_d  = cyc_q;
    ptgt_d = ptgt_q;
    case (state_q)
      LOAD: begin
        if (accept) begin
          r_d[0] = bus.in_data;
          for (int i = 0; i < N - 1; i++) r_d[i+1] = r_q[i];
          if (cnt_q == C_LAST) begin
            cnt_d  = '0;
            pass_d = '0;
            cyc_d  = '0;
            ptgt_d = rank_ptgt;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      SORT: begin
        // R[N-1] tracks the running max; the last cycle of a full pass drops it.
        r_d[0] = cs_min;
        for (int i = 0; i < N - 2; i++) r_d[i+1] = r_q[i];
        if (pass_q != ptgt_q && cyc_q == C_LAST) begin
          r_d[N-1] = r_q[N-2];
          cyc_d    = '0;
          pass_d   = pass_q + 1'b1;
        end else begin
          r_d[N-1] = cs_max;
          cyc_d    = cyc_q + 1'b1;
        end
      end
      OUT: begin
        if (bus.out_ready) cnt_d = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == LOAD);
    bus.out_valid = (state_q == OUT);
    bus.out_data  = (state_q == OUT) ? r_q[N-1] : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_median_stream.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_median_stream : scoreboard bench for median_stream. Rev 1.0     |
// +--------------------------------------------------------------------+
module tb_median_stream;

  localparam int WIDTH = 8;
  localparam int N     = 9;

  typedef logic [N-1:0][WIDTH-1:0] win_t;
  typedef struct {
    logic [WIDTH-1:0] data;
    int               lat;
  } exp_t;

  localparam win_t W1   = {8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
  localparam win_t W7F  = {9{8'h7F}};
  localparam win_t WALT = {8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF};
  localparam win_t W2   = {8'd20, 8'd10, 8'd50, 8'd40, 8'd30, 8'd90, 8'd80, 8'd70, 8'd60};
  localparam win_t WP   = {8'd8, 8'd0, 8'd7, 8'd1, 8'd6, 8'd2, 8'd5, 8'd3, 8'd4};

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  int   checks   = 0;
  int   errors   = 0;
  int   edge_cnt = 0;
  exp_t sb[$];

  median_stream_if #(.WIDTH(WIDTH)) bus ();
`ifdef MEDIAN_STREAM_RANK_EN
  logic [$clog2(N+1)-1:0] rank = '0;
`endif

  median_stream #(.WIDTH(WIDTH), .N(N)) dut (
    .CLK  (CLK),
    .nRST (nRST),
`ifdef MEDIAN_STREAM_RANK_EN
    .rank (rank),
`endif
    .bus  (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Monitor: observes accepts and outputs, compares against the queue head.
  int   acc_n    = 0;
  int   last_acc = 0;
  logic prev_ov  = 1'b0;
  always @(negedge CLK) begin
    if (!nRST) begin
      acc_n   = 0;
      prev_ov = 1'b0;
    end else begin
      if (bus.out_valid) begin
        chk("in_ready_low_in_out", int'(bus.in_ready), 0);
        if (sb.size() == 0) begin
          fail_now("unexpected_output");
        end else begin
          chk("out_data", int'(bus.out_data), int'(sb[0].data));
          if (!prev_ov) chk("latency", edge_cnt - last_acc, sb[0].lat);
          if (bus.out_ready) void'(sb.pop_front());
        end
      end else begin
        chk("out_data_idle_zero", int'(bus.out_data), 0);
      end
      if (bus.in_valid && bus.in_ready) begin
        acc_n++;
        if (acc_n % N == 0) last_acc = edge_cnt + 1;
      end
      prev_ov = bus.out_valid;
    end
  end

  task automatic send(input logic [WIDTH-1:0] d);
    logic ok;
    int   guard;
    ok    = 1'b0;
    guard = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    while (!ok && guard < 300) begin
      @(negedge CLK);
      ok = bus.in_ready;
      @(posedge CLK);
      #1;
      guard++;
    end
    bus.in_valid = 1'b0;
    if (!ok) fail_now("send_timeout");
  endtask

  task automatic send_win(input win_t v, input logic [WIDTH-1:0] exp, input int lat,
                          input bit push, input bit gap);
    exp_t e;
    e.data = exp;
    e.lat  = lat;
    if (push) sb.push_back(e);
    for (int i = N - 1; i >= 0; i--) begin
      send(v[i]);
      if (gap) begin
        @(posedge CLK);
        #1;
      end
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 400) begin
      @(posedge CLK);
      #1;
      guard++;
    end
    if (sb.size() != 0) begin
      fail_now("drain_timeout");
      sb.delete();
    end
  endtask

  task automatic pulse_reset();
    nRST = 1'b0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_in_ready", int'(bus.in_ready), 1);
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_out_data", int'(bus.out_data), 0);
    nRST = 1'b1;

    // Basic median, back-to-back samples.
    send_win(W1, 8'd5, 44, 1'b1, 1'b0);
    drain();
    chk("in_ready_after_out", int'(bus.in_ready), 1);
    chk("out_valid_after_out", int'(bus.out_valid), 0);

    // All-equal window, then alternating extremes.
    send_win(W7F, 8'h7F, 44, 1'b1, 1'b0);
    send_win(WALT, 8'hFF, 44, 1'b1, 1'b0);
    drain();

    // Sparse input valid.
    send_win(W1, 8'd5, 44, 1'b1, 1'b1);
    drain();

    // Back-pressure in OUT with input offered.
    bus.out_ready = 1'b0;
    send_win(W2, 8'd50, 44, 1'b1, 1'b0);
    guard = 0;
    while (!bus.out_valid && guard < 100) begin
      @(posedge CLK);
      #1;
      guard++;
    end
    if (!bus.out_valid) fail_now("hold_wait_out_valid");
    bus.in_data  = 8'hAA;
    bus.in_valid = 1'b1;
    repeat (10) begin
      @(negedge CLK);
      chk("hold_in_ready", int'(bus.in_ready), 0);
      chk("hold_out_valid", int'(bus.out_valid), 1);
      chk("hold_out_data", int'(bus.out_data), 50);
    end
    @(posedge CLK);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge CLK);
    #1;
    chk("release_in_ready", int'(bus.in_ready), 1);
    chk("release_out_valid", int'(bus.out_valid), 0);
    send_win(W1, 8'd5, 44, 1'b1, 1'b0);
    drain();

    // Reset in the middle of sorting.
    send_win(W1, 8'd0, 0, 1'b0, 1'b0);
    chk("sort_in_ready", int'(bus.in_ready), 0);
    repeat (20) @(posedge CLK);
    #1;
    pulse_reset();
    chk("sortrst_out_valid", int'(bus.out_valid), 0);
    chk("sortrst_in_ready", int'(bus.in_ready), 1);
    chk("sortrst_out_data", int'(bus.out_data), 0);
    for (int i = 0; i < N; i++) chk("sortrst_r_zero", int'(dut.r_q[i]), 0);
    send_win(W1, 8'd5, 44, 1'b1, 1'b0);
    drain();

    // Reset with a partial window loaded.
    send(8'd200);
    send(8'd201);
    send(8'd202);
    send(8'd203);
    pulse_reset();
    send_win(W1, 8'd5, 44, 1'b1, 1'b0);
    drain();

`ifdef MEDIAN_STREAM_RANK_EN
    rank = 4'd1;
    send_win(WP, 8'd8, 8, 1'b1, 1'b0);
    drain();
    rank = 4'd9;
    send_win(WP, 8'd0, 80, 1'b1, 1'b0);
    drain();
    rank = 4'd0;
    send_win(WP, 8'd4, 44, 1'b1, 1'b0);
    drain();
    rank = 4'd10;
    send_win(WP, 8'd4, 44, 1'b1, 1'b0);
    drain();
`else
    send_win(WP, 8'd4, 44, 1'b1, 1'b0);
    drain();
`endif

    repeat (5) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/median_stream.md
MEDIAN_STREAM -- requirements
Module: median_stream

Interface
REQ-001 Parameter: WIDTH, 8, sample bit width (unsigned), >= 1.
REQ-002 Parameter: N, 9, window length in samples; odd, >= 3.
REQ-003 Port: CLK  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: nRST  input  1  reset, synchronous, active-low.
REQ-005 Port: in_data  input  WIDTH  sample to load.
REQ-006 Port: in_valid  input  1  in_data valid.
REQ-007 Port: in_ready  output  1  block accepts a sample this cycle.
REQ-008 Port: out_data  output  WIDTH  selected order statistic, 0 when out_valid low.
REQ-009 Port: out_valid  output  1  out_data valid.
REQ-010 Port: out_ready  input  1  consumer accepts out_data.
REQ-011 Port (only with MEDIAN_STREAM_RANK_EN): rank  input  $clog2(N+1)  1 = largest .. N = smallest.

Function
REQ-012 The block SHALL hold an N-entry register chain R[0..N-1] and one compare-exchange on R[N-2]/R[N-1] giving MAX and MIN.
REQ-013 The FSM SHALL have states LOAD, SORT, OUT; in_ready = (state == LOAD), out_valid = (state == OUT).
REQ-014 In LOAD, on in_valid && in_ready, the chain SHALL shift: R[0] <= in_data, R[i+1] <= R[i], R[N-1] <= R[N-2]; without accept, R SHALL hold.
REQ-015 The edge accepting the N-th sample of a window SHALL enter SORT with pass and cycle counters at 0.
REQ-016 In SORT, every cycle R[0] <= MIN, R[i+1] <= R[i] for i in 0..N-3; R[N-1] <= R[N-2] on the last cycle (index N-1) of a full pass, else R[N-1] <= MAX.
REQ-017 SORT SHALL run P = r-1 full passes of N cycles, then N-1 further cycles with R[N-1] <= MAX, then enter OUT; r = (N+1)/2 (median) unless REQ-024 applies.
REQ-018 Latency: out_valid SHALL rise exactly P*N + N-1 edges after the edge accepting the N-th sample (N=9 median: 44).
REQ-019 In OUT, out_data = R[N-1] and R SHALL hold; out_valid && out_ready SHALL return to LOAD with sample count 0 on that edge.
REQ-020 In OUT, in_valid SHALL be ignored (in_ready low); no sample is lost or accepted.
REQ-021 Equal samples SHALL produce the tied value; comparisons are unsigned, full WIDTH, no overflow possible.
REQ-022 Windows SHALL be non-overlapping: each output consumes N fresh samples.

Reset
REQ-023 When nRST is low at an edge: state = LOAD, all counters 0, all R = 0, out_valid = 0, out_data = 0, in_ready = 1 from the next cycle; applies in any state, mid-window or mid-sort, and discards the partial window.

Configuration
REQ-024 With MEDIAN_STREAM_RANK_EN defined, port rank SHALL exist, be sampled on the edge accepting the N-th sample, and set r; rank 0 or rank > N SHALL be treated as (N+1)/2.
REQ-025 Without MEDIAN_STREAM_RANK_EN, port rank SHALL be absent and r SHALL be the constant (N+1)/2.

Structure
REQ-026 Package median_pkg SHALL hold the FSM state enum typedef (LOAD, SORT, OUT) and the counter-width helper constant function.
REQ-027 The compare-exchange SHALL be sub-module cmp_swap (parameter WIDTH; inputs A, B; outputs MAX, MIN), purely combinational.
REQ-028 Sample, pass and cycle counters SHALL be sized $clog2(N) bits each, with no wrap beyond N-1.

Verification
REQ-029 N=9, WIDTH=8, inputs 9,1,8,2,7,3,6,4,5 back-to-back, out_ready=1 -> out_data=5, out_valid high 44 edges after last accept, then in_ready=1.
REQ-030 Nine samples all 0x7F, then nine alternating 0x00/0xFF starting 0xFF -> outputs 0x7F then 0xFF.
REQ-031 in_valid high every other cycle, same values as REQ-029 -> out_data=5, latency still 44 from 9th accept.
REQ-032 out_ready held low 10 cycles in OUT while in_valid=1 -> out_data stable, in_ready=0, no sample accepted; release -> LOAD next cycle.
REQ-033 nRST low for one edge mid-SORT -> out_valid 0, R all 0, in_ready=1; next full window of REQ-029 gives 5.
REQ-034 MEDIAN_STREAM_RANK_EN, permutation of 0..8: rank=1 -> 8 after 8 edges; rank=9 -> 0 after 80 edges; rank=0 -> 4 after 44 edges.
